// File: rtl/sa_pkg.sv
// Shared constants and state encoding for the systolic-array sequencer.
package sa_pkg;

    localparam int unsigned N_DEFAULT = 32;
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned IDX_W     = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_COMPUTE,
        ST_DRAIN,
        ST_FIN
    } state_t;

    function automatic int unsigned load_len(input int unsigned n);
        return n;
    endfunction

    function automatic int unsigned compute_len(input int unsigned n);
        return 2 * n - 1;
    endfunction

    function automatic int unsigned drain_len(input int unsigned n);
        return n;
    endfunction

endpackage

// File: rtl/sa_seq_ctrl_if.sv
// Control/strobe bundle between a pass requester and the sequencer.
interface sa_seq_ctrl_if;
    import sa_pkg::*;

    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic             w_load_en;
    logic [IDX_W-1:0] w_row_sel;
    logic             x_feed_en;
    logic [IDX_W-1:0] x_col_idx;
    logic             acc_clr;
    logic             out_valid;
    logic [IDX_W-1:0] out_row_idx;
    logic [CNT_W-1:0] phase_cnt;

    modport master (
        output start, abort,
        input  busy, done, w_load_en, w_row_sel, x_feed_en, x_col_idx,
               acc_clr, out_valid, out_row_idx, phase_cnt
    );

    modport slave (
        input  start, abort,
        output busy, done, w_load_en, w_row_sel, x_feed_en, x_col_idx,
               acc_clr, out_valid, out_row_idx, phase_cnt
    );

endinterface

// File: rtl/sa_phase_counter.sv
// 6-bit in-phase cycle counter; clear wins over enable.
module sa_phase_counter
    import sa_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sa_seq_ctrl.sv
// Sequencer for one systolic-array pass: weight load, compute, drain, finish.
module sa_seq_ctrl
    import sa_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             w_load_en,
    output logic [IDX_W-1:0] w_row_sel,
    output logic             x_feed_en,
    output logic [IDX_W-1:0] x_col_idx,
    output logic             acc_clr,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_row_idx,
    output logic [CNT_W-1:0] phase_cnt
);

    localparam logic [CNT_W-1:0] LOAD_LAST    = CNT_W'(load_len(N) - 1);
    localparam logic [CNT_W-1:0] COMPUTE_LAST = CNT_W'(compute_len(N) - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(drain_len(N) - 1);
    localparam logic [CNT_W-1:0] FEED_LIMIT   = CNT_W'(N);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clr;
    logic             cnt_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_LOAD_W;
                end
            end
            ST_LOAD_W: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cnt == LOAD_LAST) begin
                    state_d = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cnt == COMPUTE_LAST) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cnt == DRAIN_LAST) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Clearing on the state change makes count 0 on the first cycle of every phase.
    assign cnt_clr = (state_d != state_q);
    assign cnt_en  = (state_q == ST_LOAD_W) || (state_q == ST_COMPUTE) ||
                     (state_q == ST_DRAIN);

    sa_phase_counter u_phase_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (cnt)
    );

    // Outputs decode only registered state and count, never the inputs.
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        w_load_en   = 1'b0;
        w_row_sel   = '0;
        x_feed_en   = 1'b0;
        x_col_idx   = '0;
        acc_clr     = 1'b0;
        out_valid   = 1'b0;
        out_row_idx = '0;
        phase_cnt   = cnt;
        case (state_q)
            ST_LOAD_W: begin
                busy      = 1'b1;
                w_load_en = 1'b1;
                w_row_sel = cnt[IDX_W-1:0];
                acc_clr   = (cnt == '0);
            end
            ST_COMPUTE: begin
                busy = 1'b1;
                if (cnt < FEED_LIMIT) begin
                    x_feed_en = 1'b1;
                    x_col_idx = cnt[IDX_W-1:0];
                end
            end
            ST_DRAIN: begin
                busy        = 1'b1;
                out_valid   = 1'b1;
                out_row_idx = cnt[IDX_W-1:0];
            end
            ST_FIN: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sa_seq_ctrl.sv
// Directed bench for sa_seq_ctrl at N=32 and N=2 against a cycle-indexed model.
module tb_sa_seq_ctrl;
    import sa_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sa_seq_ctrl_if ia();
    sa_seq_ctrl_if ib();

    sa_seq_ctrl #(.N(32)) u_dut_a (
        .clk(clk), .rst(rst), .start(ia.start), .abort(ia.abort),
        .busy(ia.busy), .done(ia.done), .w_load_en(ia.w_load_en),
        .w_row_sel(ia.w_row_sel), .x_feed_en(ia.x_feed_en),
        .x_col_idx(ia.x_col_idx), .acc_clr(ia.acc_clr),
        .out_valid(ia.out_valid), .out_row_idx(ia.out_row_idx),
        .phase_cnt(ia.phase_cnt)
    );

    sa_seq_ctrl #(.N(2)) u_dut_b (
        .clk(clk), .rst(rst), .start(ib.start), .abort(ib.abort),
        .busy(ib.busy), .done(ib.done), .w_load_en(ib.w_load_en),
        .w_row_sel(ib.w_row_sel), .x_feed_en(ib.x_feed_en),
        .x_col_idx(ib.x_col_idx), .acc_clr(ib.acc_clr),
        .out_valid(ib.out_valid), .out_row_idx(ib.out_row_idx),
        .phase_cnt(ib.phase_cnt)
    );

    logic [26:0] va;
    logic [26:0] vb;
    assign va = {ia.busy, ia.done, ia.w_load_en, ia.w_row_sel, ia.x_feed_en,
                 ia.x_col_idx, ia.acc_clr, ia.out_valid, ia.out_row_idx, ia.phase_cnt};
    assign vb = {ib.busy, ib.done, ib.w_load_en, ib.w_row_sel, ib.x_feed_en,
                 ib.x_col_idx, ib.acc_clr, ib.out_valid, ib.out_row_idx, ib.phase_cnt};

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected output vector k cycles after the cycle in which start was sampled.
    function automatic logic [26:0] exp_vec(input int n, input int k);
        bit busy, fin, load, comp, drain, feed, acc;
        int row, col, orow, pc;
        busy  = (k >= 1) && (k <= 4 * n);
        load  = (k >= 1) && (k <= n);
        comp  = (k > n) && (k <= 3 * n - 1);
        drain = (k >= 3 * n) && (k <= 4 * n - 1);
        fin   = (k == 4 * n);
        feed  = comp && (k <= 2 * n);
        acc   = (k == 1);
        row   = load ? k - 1 : 0;
        col   = feed ? k - n - 1 : 0;
        orow  = drain ? k - 3 * n : 0;
        pc    = load ? k - 1 : (comp ? k - n - 1 : (drain ? k - 3 * n : 0));
        return {busy, fin, load, 5'(row), feed, 5'(col), acc, drain, 5'(orow), 6'(pc)};
    endfunction

    int done_cnt;
    int first_done;
    int second_done;

    initial begin
        rst = 1'b1;
        ia.start = 1'b0; ia.abort = 1'b0;
        ib.start = 1'b0; ib.abort = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_a", 32'(va), 32'd0);
        check("reset_b", 32'(vb), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single pass, N=32: full cycle-by-cycle comparison.
        ia.start = 1'b1;
        for (int k = 1; k <= 130; k++) begin
            @(negedge clk);
            ia.start = 1'b0;
            check($sformatf("pass32_c%0d", k), 32'(va), 32'(exp_vec(32, k)));
        end

        // Single pass, N=2.
        ib.start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            ib.start = 1'b0;
            check($sformatf("pass2_c%0d", k), 32'(vb), 32'(exp_vec(2, k)));
        end

        // start held for 300 cycles: two completions at 128 and 257.
        done_cnt = 0; first_done = -1; second_done = -1;
        ia.start = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (k == 299) ia.start = 1'b0;
            if (ia.done) begin
                done_cnt++;
                if (done_cnt == 1) first_done = k;
                if (done_cnt == 2) second_done = k;
            end
        end
        check("held_done_count", 32'(done_cnt), 32'd2);
        check("held_done1_cycle", 32'(first_done), 32'd128);
        check("held_done2_cycle", 32'(second_done), 32'd257);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("held_cleanup", 32'(va), 32'd0);
        @(negedge clk);

        // Abort at COMPUTE count=10.
        ia.start = 1'b1;
        for (int k = 1; k <= 43; k++) begin
            @(negedge clk);
            ia.start = 1'b0;
        end
        check("abort_pre_state", 32'(va), 32'(exp_vec(32, 43)));
        check("abort_pre_cnt", 32'(ia.phase_cnt), 32'd10);
        ia.abort = 1'b1;
        @(negedge clk);
        ia.abort = 1'b0;
        check("abort_outputs", 32'(va), 32'd0);
        check("abort_busy", 32'(ia.busy), 32'd0);
        done_cnt = 0;
        for (int k = 0; k < 140; k++) begin
            @(negedge clk);
            if (ia.done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);

        // Reset at DRAIN count=5.
        ia.start = 1'b1;
        for (int k = 1; k <= 101; k++) begin
            @(negedge clk);
            ia.start = 1'b0;
        end
        check("rst_pre_cnt", 32'(ia.phase_cnt), 32'd5);
        check("rst_pre_valid", 32'(ia.out_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_outputs", 32'(va), 32'd0);
        done_cnt = 0;
        for (int k = 0; k < 140; k++) begin
            @(negedge clk);
            if (ia.done) done_cnt++;
        end
        check("rst_no_done", 32'(done_cnt), 32'd0);

        // start and abort together in IDLE: stays idle.
        ia.start = 1'b1; ia.abort = 1'b1;
        ib.start = 1'b1; ib.abort = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("start_abort_a_c%0d", k), 32'(va), 32'd0);
            check($sformatf("start_abort_b_c%0d", k), 32'(vb), 32'd0);
        end
        ia.start = 1'b0; ia.abort = 1'b0;
        ib.start = 1'b0; ib.abort = 1'b0;
        @(negedge clk);
        check("idle_after_a", 32'(va), 32'd0);
        check("idle_after_b", 32'(vb), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sa_seq_ctrl.md
SA_SEQ_CTRL -- requirements
Module: sa_seq_ctrl

Interface
REQ-001 SHALL have parameter N, default 32: array dimension, legal range 2..32, so that 2N-1 fits in 6 bits.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request one matrix pass; sampled only in IDLE.
REQ-005 SHALL have port abort, input, 1 bit: terminate the current pass.
REQ-006 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse at pass completion.
REQ-008 SHALL have port w_load_en, output, 1 bit: weight-load strobe.
REQ-009 SHALL have port w_row_sel, output, 5 bits: weight row being loaded.
REQ-010 SHALL have port x_feed_en, output, 1 bit: activation feed strobe.
REQ-011 SHALL have port x_col_idx, output, 5 bits: activation column being fed.
REQ-012 SHALL have port acc_clr, output, 1 bit: one-cycle accumulator clear.
REQ-013 SHALL have port out_valid, output, 1 bit: result row valid.
REQ-014 SHALL have port out_row_idx, output, 5 bits: result row index.
REQ-015 SHALL have port phase_cnt, output, 6 bits: current in-phase count, for debug.

Function
REQ-016 SHALL implement the states IDLE, LOAD_W, COMPUTE, DRAIN and FIN.
REQ-017 SHALL keep an internal 6-bit phase count that clears to 0 on every state change and increments by 1 each cycle while in a counting state.
REQ-018 SHALL go IDLE->LOAD_W on the cycle after start=1 is sampled in IDLE, and assert acc_clr for that single transition cycle only.
REQ-019 SHALL keep LOAD_W for exactly N cycles with w_load_en=1 and w_row_sel=count, then enter COMPUTE.
REQ-020 SHALL keep COMPUTE for exactly 2N-1 cycles, with x_feed_en=1 and x_col_idx=count when count<N, and x_feed_en=0 and x_col_idx=0 otherwise.
REQ-021 SHALL keep DRAIN for exactly N cycles with out_valid=1 and out_row_idx=count, then enter FIN.
REQ-022 SHALL remain in FIN for one cycle with done=1 and then return to IDLE.
REQ-023 SHALL make the total duration from start sample to the done pulse exactly 1+N+(2N-1)+N cycles; for N=32 this is 128 cycles.
REQ-024 SHALL ignore start whenever busy=1; there SHALL be no queuing of requests.
REQ-025 SHALL, when abort=1 in any non-IDLE state, enter IDLE on the next edge, deassert all strobes at that edge, and not assert done.
REQ-026 SHALL give abort priority over start when both are high in IDLE, so the block stays in IDLE.
REQ-027 SHALL drive index outputs to 0 and all strobes low whenever the associated strobe is inactive.
REQ-028 SHALL make all outputs registered or decoded only from registered state and count, with no combinational path from an input to an output.

Reset
REQ-029 SHALL, with rst=1 at an edge, set state=IDLE, count=0, busy=0, done=0, all strobes=0 and all indices=0.
REQ-030 SHALL let rst override abort and start, and apply mid-pass with the same effect as REQ-029 and no done pulse.

Structure
REQ-031 SHALL take the state encoding, N default and phase-length constants (N, 2N-1, N) from shared package sa_pkg.
REQ-032 SHALL instantiate one sub-module, sa_phase_counter: a 6-bit counter with sync active-high reset, a clear input and an enable input, where clear has priority over enable.

Verification
REQ-033 SHALL cover reset, then a start pulse: w_load_en high on cycles 1-32 with w_row_sel 0..31, x_feed_en high on cycles 33-64, COMPUTE ending at cycle 95, out_valid on cycles 96-127, and done at cycle 128.
REQ-034 SHALL cover start held high for 300 cycles: exactly two passes, with done at cycles 128 and 257.
REQ-035 SHALL cover abort asserted at COMPUTE count=10: IDLE on the next cycle, no done, and busy=0.
REQ-036 SHALL cover rst asserted at DRAIN count=5: all outputs 0 on the next cycle and no done.
REQ-037 SHALL cover start and abort both high in IDLE: the block remains IDLE with busy=0.
REQ-038 SHALL cover N=2: LOAD_W 2 cycles, COMPUTE 3 cycles, DRAIN 2 cycles, and done 8 cycles after start.
